// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the 32-bit word UART transmitter: FSM encoding and default bit timing.
package uart_word_tx_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam logic [1:0] LAST_SEL = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      START_B = 3'd2,
      DATA    = 3'd3,
      STOP_B  = 3'd4
   } state_t;

endpackage

// File: rtl/uart_word_tx_if.sv
// Bundle between the word transmitter, its requester and the external 4:1 byte selector.
interface uart_word_tx_if;
   import uart_word_tx_pkg::*;

   // START is a level request, accepted only on a cycle where BUSY is low; while BUSY
   // is high it is ignored, never queued. Byte_In must reflect SEL during LOAD.
   logic       START;
   logic [7:0] Byte_In;
   logic [1:0] SEL;
   logic       TX;
   logic       BUSY;
   logic       DONE;
   state_t     state;

   modport master (
      output START,
      input  SEL, TX, BUSY, DONE, state
   );

   modport slave (
      input  START, Byte_In,
      output SEL, TX, BUSY, DONE, state
   );

endinterface

// File: rtl/uart_word_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable by a synchronous clear.
module baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 32-bit word as four 8N1 UART frames, byte 0 first, fetching each byte via SEL.
module uart_word_tx
   import uart_word_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic           CLK,
   input  logic           RST_N,
   uart_word_tx_if.slave  bus
);

   state_t     state;
   state_t     next_state;
   logic       tick;
   logic [7:0] sr;
   logic [7:0] sr_next;
   logic [2:0] bit_cnt;
   logic [2:0] bit_cnt_next;
   logic [1:0] sel_q;
   logic [1:0] sel_next;
   logic       tx_q;
   logic       tx_next;
   logic       done_q;
   logic       done_next;

   // Timer restarts in LOAD so every frame's start bit begins on a clean bit boundary.
   baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   ((state == IDLE) || (state == LOAD)),
      .tick  (tick)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.START) next_state = LOAD;
         LOAD:    next_state = START_B;
         START_B: if (tick) next_state = DATA;
         DATA:    if (tick && bit_cnt == 3'd7) next_state = STOP_B;
         STOP_B:  if (tick) next_state = (sel_q == LAST_SEL) ? IDLE : LOAD;
         default: next_state = IDLE;
      endcase
   end

   // TX is computed from the upcoming state so the registered line changes with the state.
   always_comb begin
      sr_next      = sr;
      bit_cnt_next = bit_cnt;
      sel_next     = sel_q;
      done_next    = 1'b0;
      tx_next      = 1'b1;
      case (state)
         LOAD: begin
            sr_next      = bus.Byte_In;
            bit_cnt_next = '0;
         end
         DATA: begin
            if (tick) begin
               sr_next      = {1'b0, sr[7:1]};
               bit_cnt_next = bit_cnt + 3'd1;
            end
         end
         STOP_B: begin
            if (tick) begin
               sel_next  = sel_q + 2'd1;
               done_next = (sel_q == LAST_SEL);
            end
         end
         default: ;
      endcase
      case (next_state)
         START_B: tx_next = 1'b0;
         DATA:    tx_next = sr_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sr      <= '0;
         bit_cnt <= '0;
         sel_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         sr      <= sr_next;
         bit_cnt <= bit_cnt_next;
         sel_q   <= sel_next;
         tx_q    <= tx_next;
         done_q  <= done_next;
      end
   end

   assign bus.SEL   = sel_q;
   assign bus.TX    = tx_q;
   assign bus.BUSY  = (state != IDLE);
   assign bus.DONE  = done_q;
   assign bus.state = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with an external byte selector and a cycle-position word model.
module tb_uart_word_tx;
   import uart_word_tx_pkg::*;

   localparam int CPB      = 4;
   localparam int BYTE_CYC = 1 + 10 * CPB;
   localparam int WORD_CYC = 4 * BYTE_CYC;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] dato  = 32'hA5C3_0F81;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   uart_word_tx_if u_if ();

   uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (u_if)
   );

   // External Out_Mux byte selector
   always_comb begin
      case (u_if.SEL)
         2'd0:    u_if.Byte_In = dato[7:0];
         2'd1:    u_if.Byte_In = dato[15:8];
         2'd2:    u_if.Byte_In = dato[23:16];
         default: u_if.Byte_In = dato[31:24];
      endcase
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Word model: position m_p counts cycles since LOAD of byte 0; 41 cycles per byte.
   bit         m_act  = 1'b0;
   bit         m_done = 1'b0;
   int         m_p    = 0;
   logic [7:0] m_cur  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act  = 1'b0;
         m_done = 1'b0;
         m_p    = 0;
      end else if (m_act) begin
         if (m_p % BYTE_CYC == 0) m_cur = dato[8*(m_p/BYTE_CYC) +: 8];
         m_p = m_p + 1;
         if (m_p == WORD_CYC) begin
            m_act  = 1'b0;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (u_if.START) begin
            m_act = 1'b1;
            m_p   = 0;
         end
      end
   end

   // Compare process, UART receiver and DONE monitor, all sampled 2 time units after the edge.
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   bit         rx_act   = 1'b0;
   int         rx_c     = 0;
   logic [7:0] rx_byte  = '0;

   always @(posedge clk) begin
      int   off;
      logic e_tx;
      logic [1:0] e_sel;
      logic e_busy;
      logic e_done;
      #2;
      if (m_act) begin
         off    = m_p % BYTE_CYC;
         e_sel  = 2'(m_p / BYTE_CYC);
         e_busy = 1'b1;
         e_done = 1'b0;
         if (off == 0)            e_tx = 1'b1;
         else if (off <= CPB)     e_tx = 1'b0;
         else if (off <= 9 * CPB) e_tx = m_cur[(off - CPB - 1) / CPB];
         else                     e_tx = 1'b1;
      end else begin
         e_tx   = 1'b1;
         e_sel  = 2'd0;
         e_busy = 1'b0;
         e_done = m_done;
      end
      check($sformatf("cyc%0d_tx_sel_busy_done", cyc),
            {27'd0, u_if.TX, u_if.SEL, u_if.BUSY, u_if.DONE},
            {27'd0, e_tx, e_sel, e_busy, e_done});

      if (u_if.DONE) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end

      if (!rst_n) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (u_if.TX == 1'b0) begin
            rx_act = 1'b1;
            rx_c   = 0;
         end
      end else begin
         rx_c = rx_c + 1;
         if (rx_c >= 6 && rx_c <= 34 && (rx_c - 6) % CPB == 0)
            rx_byte[(rx_c - 6) / CPB] = u_if.TX;
         if (rx_c == 38) begin
            check("rx_stop_bit", {31'd0, u_if.TX}, 32'd1);
            got_q.push_back(rx_byte);
         end
         if (rx_c == 39) rx_act = 1'b0;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Pulses START for one cycle and pins the LOAD and first-start-bit latency.
   task automatic pulse_start(output int start_edge);
      @(negedge clk);
      u_if.START = 1'b1;
      start_edge = cyc + 1;
      @(posedge clk);
      #2;
      check("load_busy", {31'd0, u_if.BUSY}, 32'd1);
      check("load_tx", {31'd0, u_if.TX}, 32'd1);
      @(negedge clk);
      u_if.START = 1'b0;
      @(posedge clk);
      #2;
      check("first_start_bit", {31'd0, u_if.TX}, 32'd0);
   endtask

   task automatic wait_done(input int prev, input string name);
      int n;
      n = 0;
      while (done_cnt == prev && n < 500) begin
         @(negedge clk);
         n = n + 1;
      end
      if (done_cnt == prev) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_bytes(input string name);
      check({name, "_rx_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())
            check($sformatf("%s_rx_byte%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      end
   endtask

   task automatic clear_run();
      got_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   initial begin
      int se;
      int d1;
      u_if.START = 1'b0;
      wait_cycles(3);
      check("rst_tx", {31'd0, u_if.TX}, 32'd1);
      check("rst_sel", {30'd0, u_if.SEL}, 32'd0);
      check("rst_busy", {31'd0, u_if.BUSY}, 32'd0);
      check("rst_done", {31'd0, u_if.DONE}, 32'd0);
      rst_n = 1'b1;
      wait_cycles(3);

      // Single word
      clear_run();
      exp_q = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
      pulse_start(se);
      wait_done(0, "s1");
      check("s1_done_latency", done_cyc - se, WORD_CYC);
      wait_cycles(10);
      check("s1_done_count", done_cnt, 1);
      check_bytes("s1");

      // START again during byte 2 is ignored
      clear_run();
      exp_q = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
      pulse_start(se);
      wait_until(se + 2 * BYTE_CYC + 10);
      @(negedge clk) u_if.START = 1'b1;
      @(negedge clk) u_if.START = 1'b0;
      wait_done(0, "s3");
      check("s3_done_latency", done_cyc - se, WORD_CYC);
      wait_cycles(30);
      check("s3_idle_after", {31'd0, u_if.BUSY}, 32'd0);
      check("s3_done_count", done_cnt, 1);
      check_bytes("s3");

      // Reset in DATA of byte 1 aborts the word
      clear_run();
      exp_q = '{8'h81};
      pulse_start(se);
      wait_until(se + BYTE_CYC + 20);
      rst_n = 1'b0;
      #1;
      check("s4_rst_tx", {31'd0, u_if.TX}, 32'd1);
      check("s4_rst_sel", {30'd0, u_if.SEL}, 32'd0);
      check("s4_rst_busy", {31'd0, u_if.BUSY}, 32'd0);
      check("s4_rst_state", {29'd0, u_if.state}, {29'd0, IDLE});
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(WORD_CYC + 20);
      check("s4_no_done", done_cnt, 0);
      check("s4_still_idle", {31'd0, u_if.BUSY}, 32'd0);
      check_bytes("s4_abort");
      clear_run();
      exp_q = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
      pulse_start(se);
      wait_done(0, "s4r");
      check("s4_retx_latency", done_cyc - se, WORD_CYC);
      wait_cycles(5);
      check_bytes("s4_retx");

      // START held high: back-to-back words
      clear_run();
      exp_q = '{8'h81, 8'h0F, 8'hC3, 8'hA5, 8'h81, 8'h0F, 8'hC3, 8'hA5};
      @(negedge clk);
      u_if.START = 1'b1;
      se = cyc + 1;
      wait_done(0, "s5a");
      d1 = done_cyc;
      check("s5_first_latency", d1 - se, WORD_CYC);
      @(posedge clk);
      #2;
      check("s5_reload_busy", {31'd0, u_if.BUSY}, 32'd1);
      check("s5_reload_state", {29'd0, u_if.state}, {29'd0, LOAD});
      wait_cycles(20);
      u_if.START = 1'b0;
      wait_done(1, "s5b");
      check("s5_word_spacing", done_cyc - d1, WORD_CYC + 1);
      wait_cycles(10);
      check("s5_done_count", done_cnt, 2);
      check_bytes("s5");

      // Dato changes while byte 1 is on the line
      clear_run();
      exp_q = '{8'h81, 8'h0F, 8'h34, 8'h12};
      pulse_start(se);
      wait_until(se + BYTE_CYC + 15);
      dato = 32'h1234_5678;
      wait_done(0, "s6");
      wait_cycles(5);
      check("s6_done_count", done_cnt, 1);
      check_bytes("s6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 434, CLK cycles per UART bit (50 MHz / 115200); legal values >= 2.
REQ-002 SHALL have port: CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port: START  input  1  request to transmit the current 32-bit word; sampled only in IDLE.
REQ-005 SHALL have port: Byte_In  input  8  selected byte from the downstream 4:1 byte selector (Out_Mux).
REQ-006 SHALL have port: SEL  output  2  registered byte index driven to the byte selector; 0 = bits [7:0] ... 3 = bits [31:24].
REQ-007 SHALL have port: TX  output  1  registered UART serial line, idle high.
REQ-008 SHALL have port: BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port: DONE  output  1  one-cycle pulse after the last stop bit of byte 3.

Function
REQ-010 SHALL implement states IDLE, LOAD, START_B, DATA, STOP_B.
REQ-011 IDLE: TX=1, SEL=0. START=1 SHALL move to LOAD on the next edge; START=0 stays in IDLE.
REQ-012 LOAD lasts exactly 1 cycle with TX=1. SEL holds the current index. Byte_In SHALL be captured into the shift register on the edge leaving LOAD.
REQ-013 START_B SHALL drive TX=0 for CLKS_PER_BIT cycles.
REQ-014 DATA SHALL drive 8 bits, LSB first, each for CLKS_PER_BIT cycles. It uses a 3-bit bit counter.
REQ-015 STOP_B SHALL drive TX=1 for CLKS_PER_BIT cycles.
REQ-016 At the end of STOP_B: if SEL<3, SEL SHALL increment and the state returns to LOAD; if SEL==3, SEL wraps to 0, the state returns to IDLE, and DONE=1 for that single cycle.
REQ-017 Bytes SHALL be sent in order SEL 0,1,2,3. That is least-significant byte first.
REQ-018 Latency: with START high at cycle n, LOAD occurs at n+1 and the first start bit begins at n+2.
REQ-019 Each byte SHALL occupy 1+10*CLKS_PER_BIT cycles. A full word SHALL occupy 4*(1+10*CLKS_PER_BIT) cycles from entering LOAD until IDLE.
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and reloads to 0 at every bit boundary. It has no drift across bits.
REQ-021 START while BUSY=1 SHALL be ignored. Requests are not queued.
REQ-022 START held high continuously SHALL start a new word on the cycle after DONE, from IDLE.
REQ-023 Byte_In changes outside LOAD SHALL have no effect on TX.
REQ-024 DONE and BUSY are mutually exclusive. DONE is asserted in the first IDLE cycle after the final stop bit.

Reset
REQ-025 RST_N low SHALL immediately force: state=IDLE, TX=1, SEL=0, BUSY=0, DONE=0, and all counters and the shift register to 0.
REQ-026 Reset asserted mid-frame SHALL abort the word without completing the current byte. No DONE is produced.
REQ-027 After RST_N deasserts, the block SHALL wait in IDLE for START.

Structure
REQ-028 A shared package SHALL hold the state encoding (3-bit enum) and the default CLKS_PER_BIT constant.
REQ-029 The bit-timing counter SHALL be one sub-module, baud_tick, producing a 1-cycle tick every CLKS_PER_BIT cycles. It has a synchronous clear used on LOAD.
REQ-030 The byte selector SHALL remain external. The bench instantiates it between SEL and Byte_In.

Verification (CLKS_PER_BIT=4, selector instantiated, Dato=32'hA5C3_0F81)
REQ-031 Scenario: pulse START for 1 cycle -> TX frames carry bytes 0x81, 0x0F, 0xC3, 0xA5 in order. SEL steps 0,1,2,3. DONE pulses once after 4*41=164 cycles from LOAD.
REQ-032 Scenario: bit timing -> every start, data and stop bit lasts exactly 4 cycles. The first start bit falls at cycle n+2.
REQ-033 Scenario: START pulsed again during byte 2 -> ignored; exactly one DONE; the bit stream is identical to scenario 1.
REQ-034 Scenario: RST_N low in DATA of byte 1 -> TX=1, SEL=0, BUSY=0 in the same cycle; no DONE; a later START retransmits from byte 0.
REQ-035 Scenario: START held high -> words are back-to-back, separated by exactly one IDLE cycle (the DONE cycle) plus LOAD.
REQ-036 Scenario: Dato changed while byte 1 is being shifted -> byte 1 on the line is unchanged; byte 2 reflects the new Dato[23:16].
